nmi_arbiter: RTL and testbench

//  Sole owner of the CPU /NMI line. Arbitrates three NMI sources (magic button, pause button,

---
 rtl/nmi_arbiter_pkg.sv | 29 ++
 rtl/cpu_bus.sv | 10 +
 rtl/edge_rise.sv | 24 ++
 rtl/nmi_arbiter.sv | 134 +++++++++++++
 tb/tb_nmi_arbiter.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nmi_arbiter_pkg.sv
// Shared types and constants for the NMI arbiter: state encoding, source bit indices,
// the NMI vector address and the fixed-priority pick helper.
package nmi_arbiter_pkg;

    typedef enum logic [1:0] {
        NMI_IDLE,
        NMI_ASSERT,
        NMI_SERVICE
    } nmi_state_t;

    localparam int unsigned NMI_SRC_MAGIC = 0;
    localparam int unsigned NMI_SRC_PAUSE = 1;
    localparam int unsigned NMI_SRC_DIV   = 2;

    localparam logic [15:0] NMI_VECTOR = 16'h0066;

    // Fixed priority magic > div > pause; returns a one-hot (or zero) grant vector.
    function automatic logic [2:0] nmi_pick(input logic [2:0] req);
        nmi_pick = '0;
        if (req[NMI_SRC_MAGIC]) begin
            nmi_pick[NMI_SRC_MAGIC] = 1'b1;
        end else if (req[NMI_SRC_DIV]) begin
            nmi_pick[NMI_SRC_DIV] = 1'b1;
        end else if (req[NMI_SRC_PAUSE]) begin
            nmi_pick[NMI_SRC_PAUSE] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/cpu_bus.sv
// CPU bus signals observed by bus monitors; strobes are active high in this bundle.
interface cpu_bus;
    logic        mreq;
    logic        m1;
    logic        rd;
    logic [15:0] a;

    modport mon (input mreq, input m1, input rd, input a);
    modport drv (output mreq, output m1, output rd, output a);
endinterface

// File: rtl/edge_rise.sv
// Per-bit rising-edge detector; falling edges are detected by feeding inverted inputs.
module edge_rise #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] prev;

    // History resets high so a level already present at reset release is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= '1;
        end else begin
            prev <= d;
        end
    end

    assign rise = d & ~prev;

endmodule

// File: rtl/nmi_arbiter.sv
// Sole owner of CPU /NMI: captures three button requests, grants one per frame edge,
// holds /NMI until the 0x0066 vector fetch and tracks the handler until it exits.
module nmi_arbiter
    import nmi_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_W = 12,
    parameter int unsigned HOLDOFF   = 2
) (
    input  logic       clk28,
    input  logic       rst_n,
    input  logic       ck35,
    cpu_bus.mon        bus,
    input  logic       n_int,
    input  logic       n_int_next,
    input  logic       req_magic,
    input  logic       req_pause,
    input  logic       req_div,
    input  logic       magic_mode,
    input  logic       div_paged,
    output logic       n_nmi,
    output logic [2:0] nmi_grant,
    output logic       busy,
    output logic       timeout_flag,
    input  logic       timeout_clr
);

    localparam int unsigned HO_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [HO_W-1:0] HO_LOAD = HO_W'(HOLDOFF);
    localparam logic [TIMEOUT_W-1:0] CNT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    nmi_state_t           state, state_n;
    logic [2:0]           pending, pending_n, pend_clr, win, magic_mask, req_rise;
    logic [2:0]           grant_n;
    logic [1:0]           fall;
    logic [TIMEOUT_W-1:0] cnt, cnt_n;
    logic [HO_W-1:0]      hold, hold_n;
    logic                 n_nmi_n, flag_n, frame_edge, ack, exit_now;

    edge_rise #(.WIDTH(3)) u_req_rise (
        .clk  (clk28),
        .rst_n(rst_n),
        .d    ({req_div, req_pause, req_magic}),
        .rise (req_rise)
    );

    edge_rise #(.WIDTH(2)) u_handler_fall (
        .clk  (clk28),
        .rst_n(rst_n),
        .d    ({~div_paged, ~magic_mode}),
        .rise (fall)
    );

    assign frame_edge = n_int & ~n_int_next;
    assign ack        = bus.m1 & bus.mreq & bus.rd & (bus.a == NMI_VECTOR);
    // Pause runs inside the magic handler, so only div exits on div_paged.
    assign exit_now   = nmi_grant[NMI_SRC_DIV] ? fall[1] : fall[0];
    assign busy       = (state != NMI_IDLE);

    always_comb begin
        magic_mask                = '0;
        magic_mask[NMI_SRC_MAGIC] = magic_mode;
    end

    always_comb begin
        state_n  = state;
        n_nmi_n  = n_nmi;
        grant_n  = nmi_grant;
        cnt_n    = cnt;
        pend_clr = '0;
        win      = '0;
        hold_n   = (frame_edge && hold != '0) ? hold - HO_W'(1) : hold;
        flag_n   = timeout_clr ? 1'b0 : timeout_flag;

        case (state)
            NMI_IDLE: begin
                if (frame_edge && hold == '0 && pending != '0) begin
                    win      = nmi_pick(pending & ~magic_mask);
                    pend_clr = win | (pending & magic_mask);
                    if (win != '0) begin
                        state_n = NMI_ASSERT;
                        n_nmi_n = 1'b0;
                        grant_n = win;
                        cnt_n   = '0;
                    end
                end
            end
            NMI_ASSERT: begin
                if (ack) begin
                    n_nmi_n = 1'b1;
                    state_n = NMI_SERVICE;
                end else if (ck35) begin
                    cnt_n = cnt + TIMEOUT_W'(1);
                    if (cnt == CNT_LAST) begin
                        n_nmi_n = 1'b1;
                        grant_n = '0;
                        flag_n  = 1'b1;
                        state_n = NMI_IDLE;
                    end
                end
            end
            NMI_SERVICE: begin
                if (exit_now) begin
                    grant_n = '0;
                    hold_n  = HO_LOAD;
                    state_n = NMI_IDLE;
                end
            end
            default: state_n = NMI_IDLE;
        endcase

        pending_n = (pending & ~pend_clr) | (req_rise & ~magic_mask);
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            state        <= NMI_IDLE;
            n_nmi        <= 1'b1;
            nmi_grant    <= '0;
            timeout_flag <= 1'b0;
            pending      <= '0;
            cnt          <= '0;
            hold         <= '0;
        end else begin
            state        <= state_n;
            n_nmi        <= n_nmi_n;
            nmi_grant    <= grant_n;
            timeout_flag <= flag_n;
            pending      <= pending_n;
            cnt          <= cnt_n;
            hold         <= hold_n;
        end
    end

endmodule

// File: tb/tb_nmi_arbiter.sv
// Bench for nmi_arbiter: directed scenarios plus randomized traffic against a
// source/phase-level reference model kept in the bench.
module tb_nmi_arbiter;

    localparam int TO_TICKS = 4095;
    localparam int HOLD     = 2;

    logic       clk28 = 1'b0;
    logic       rst_n = 1'b0;
    logic       ck35 = 1'b0, n_int = 1'b1, n_int_next = 1'b1;
    logic       req_magic = 1'b0, req_pause = 1'b0, req_div = 1'b0;
    logic       magic_mode = 1'b0, div_paged = 1'b0, timeout_clr = 1'b0;
    logic       n_nmi, busy, timeout_flag;
    logic [2:0] nmi_grant;

    cpu_bus bus_if ();

    nmi_arbiter #(.TIMEOUT_W(12), .HOLDOFF(2)) dut (
        .clk28       (clk28),
        .rst_n       (rst_n),
        .ck35        (ck35),
        .bus         (bus_if),
        .n_int       (n_int),
        .n_int_next  (n_int_next),
        .req_magic   (req_magic),
        .req_pause   (req_pause),
        .req_div     (req_div),
        .magic_mode  (magic_mode),
        .div_paged   (div_paged),
        .n_nmi       (n_nmi),
        .nmi_grant   (nmi_grant),
        .busy        (busy),
        .timeout_flag(timeout_flag),
        .timeout_clr (timeout_clr)
    );

    always #5 clk28 = ~clk28;

    int n_vec = 0, n_err = 0;
    int nmi_falls = 0;
    logic last_nmi = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: which source is being serviced (-1 none), whether its vector was fetched.
    int       m_src, m_ticks, m_hold;
    bit       m_acked, m_flag, m_pmm, m_pdp;
    bit [2:0] m_pend, m_preq;

    task automatic model_reset();
        m_src = -1; m_ticks = 0; m_hold = 0; m_acked = 0; m_flag = 0;
        m_pend = '0; m_preq = 3'b111; m_pmm = 0; m_pdp = 0;
    endtask

    task automatic model_step();
        bit       fe, ack, timed, exited;
        bit [2:0] req, rise;
        int       pick;
        req    = {req_div, req_pause, req_magic};
        fe     = n_int && !n_int_next;
        ack    = bus_if.m1 && bus_if.mreq && bus_if.rd && (bus_if.a == 16'h0066);
        rise   = req & ~m_preq;
        timed  = 0;
        exited = 0;
        if (m_src < 0) begin
            if (fe && m_hold == 0 && m_pend != 0) begin
                if (magic_mode) m_pend[0] = 0;
                pick = -1;
                if (m_pend[0]) pick = 0;
                else if (m_pend[2]) pick = 2;
                else if (m_pend[1]) pick = 1;
                if (pick >= 0) begin
                    m_src = pick; m_acked = 0; m_ticks = 0; m_pend[pick] = 0;
                end
            end
        end else if (!m_acked) begin
            if (ack) m_acked = 1;
            else if (ck35) begin
                m_ticks++;
                if (m_ticks == TO_TICKS) begin m_src = -1; timed = 1; end
            end
        end else if (m_src == 2 ? (!div_paged && m_pdp) : (!magic_mode && m_pmm)) begin
            m_src = -1; exited = 1;
        end
        if (exited) m_hold = HOLD;
        else if (fe && m_hold > 0) m_hold--;
        if (timed) m_flag = 1;
        else if (timeout_clr) m_flag = 0;
        if (magic_mode) rise[0] = 0;
        m_pend |= rise;
        m_preq = req; m_pmm = magic_mode; m_pdp = div_paged;
    endtask

    task automatic tick();
        logic [2:0] eg;
        @(posedge clk28);
        model_step();
        @(negedge clk28);
        eg = (m_src >= 0) ? 3'(1 << m_src) : 3'b000;
        check_eq("n_nmi", n_nmi, (m_src >= 0 && !m_acked) ? 1'b0 : 1'b1);
        check_eq("nmi_grant", nmi_grant, eg);
        check_eq("busy", busy, m_src >= 0);
        check_eq("timeout_flag", timeout_flag, m_flag);
        if (last_nmi && !n_nmi) nmi_falls++;
        last_nmi = n_nmi;
    endtask

    task automatic quiet();
        bus_if.m1 = 0; bus_if.mreq = 0; bus_if.rd = 0; bus_if.a = '0;
        ck35 = 0; timeout_clr = 0; n_int = 1; n_int_next = 1;
    endtask

    task automatic frame();
        n_int = 1; n_int_next = 0; tick();
        n_int = 0; n_int_next = 1; tick();
        n_int = 1; n_int_next = 1;
        repeat (3) tick();
    endtask

    task automatic fetch_vector();
        bus_if.m1 = 1; bus_if.mreq = 1; bus_if.rd = 1; bus_if.a = 16'h0066;
        tick();
        quiet();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        bit done;
        quiet();
        bus_if.a = 16'h1234;
        model_reset();
        repeat (2) @(negedge clk28);
        check_eq("rst_n_nmi", n_nmi, 1);
        check_eq("rst_grant", nmi_grant, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_flag", timeout_flag, 0);
        rst_n = 1;
        quiet();
        repeat (3) tick();

        // 1: magic grant, vector fetch, handler exit
        req_magic = 1; tick(); req_magic = 0; tick();
        n_int = 1; n_int_next = 0; tick();
        check_eq("t1_nmi_low", n_nmi, 0);
        check_eq("t1_grant", nmi_grant, 3'b001);
        n_int_next = 1;
        repeat (3) tick();
        magic_mode = 1; tick();
        fetch_vector();
        check_eq("t1_nmi_rel", n_nmi, 1);
        check_eq("t1_busy_svc", busy, 1);
        tick(); magic_mode = 0; tick();
        check_eq("t1_busy_exit", busy, 0);

        // 2: simultaneous pause+div, div first, pause after holdoff
        repeat (3) frame();
        req_pause = 1; req_div = 1; tick(); req_pause = 0; req_div = 0; tick();
        frame();
        check_eq("t2_div_grant", nmi_grant, 3'b100);
        div_paged = 1; tick();
        fetch_vector();
        div_paged = 0; tick();
        check_eq("t2_div_exit", busy, 0);
        frame(); check_eq("t2_hold1", nmi_grant, 0);
        frame(); check_eq("t2_hold2", nmi_grant, 0);
        frame(); check_eq("t2_pause_grant", nmi_grant, 3'b010);
        fetch_vector();
        magic_mode = 1; tick(); magic_mode = 0; tick();

        // 3: unacknowledged NMI times out
        repeat (3) frame();
        req_magic = 1; tick(); req_magic = 0; tick();
        frame();
        check_eq("t3_grant", nmi_grant, 3'b001);
        done = 0;
        for (int i = 0; i < 10000 && !done; i++) begin
            ck35 = (i % 2 == 1);
            tick();
            done = (m_src < 0);
        end
        ck35 = 0;
        check_eq("t3_bound", done, 1);
        check_eq("t3_nmi", n_nmi, 1);
        check_eq("t3_flag", timeout_flag, 1);
        check_eq("t3_busy", busy, 0);
        timeout_clr = 1; tick(); timeout_clr = 0; tick();
        check_eq("t3_clr", timeout_flag, 0);

        // 6: ack on the cycle the counter would reach all-ones
        req_magic = 1; tick(); req_magic = 0; tick();
        frame();
        check_eq("t6_grant", nmi_grant, 3'b001);
        done = 0;
        for (int i = 0; i < 10000 && !done; i++) begin
            ck35 = (i % 2 == 1);
            if (ck35 && m_ticks == TO_TICKS - 1) begin
                bus_if.m1 = 1; bus_if.mreq = 1; bus_if.rd = 1; bus_if.a = 16'h0066;
                done = 1;
            end
            tick();
        end
        quiet();
        check_eq("t6_bound", done, 1);
        check_eq("t6_busy", busy, 1);
        check_eq("t6_nmi", n_nmi, 1);
        check_eq("t6_flag", timeout_flag, 0);
        magic_mode = 1; tick(); magic_mode = 0; tick();
        check_eq("t6_exit", busy, 0);

        // 4: magic while handler active is dropped; held level grants once
        repeat (3) frame();
        magic_mode = 1; tick();
        req_magic = 1; tick(); req_magic = 0; tick();
        frame();
        check_eq("t4_drop_nmi", n_nmi, 1);
        check_eq("t4_drop_busy", busy, 0);
        magic_mode = 0; tick();
        frame();
        check_eq("t4_no_pending", busy, 0);
        nmi_falls = 0;
        req_magic = 1; tick();
        frame();
        check_eq("t4_grant", nmi_grant, 3'b001);
        fetch_vector();
        magic_mode = 1; tick(); magic_mode = 0; tick();
        repeat (4) frame();
        check_eq("t4_one_grant", nmi_falls, 1);
        req_magic = 0; tick();

        // 5: async reset mid-ASSERT
        repeat (3) frame();
        req_div = 1; tick(); req_div = 0; tick();
        frame();
        check_eq("t5_assert", n_nmi, 0);
        #2 rst_n = 0;
        #1;
        check_eq("t5_async_nmi", n_nmi, 1);
        check_eq("t5_async_grant", nmi_grant, 0);
        check_eq("t5_async_busy", busy, 0);
        model_reset();
        @(negedge clk28);
        @(negedge clk28);
        rst_n = 1;
        last_nmi = 1;
        tick();
        repeat (2) frame();
        check_eq("t5_no_regrant", busy, 0);

        // Randomized traffic
        for (int c = 0; c < 6000; c++) begin
            r = $urandom_range(0, 24);
            if (r == 0) begin n_int = 1; n_int_next = 0; end
            else begin
                case ($urandom_range(0, 2))
                    0: begin n_int = 1; n_int_next = 1; end
                    1: begin n_int = 0; n_int_next = 0; end
                    default: begin n_int = 0; n_int_next = 1; end
                endcase
            end
            ck35 = (c % 8 == 0);
            if ($urandom_range(0, 39) == 0) req_magic = ~req_magic;
            if ($urandom_range(0, 39) == 0) req_pause = ~req_pause;
            if ($urandom_range(0, 39) == 0) req_div = ~req_div;
            if ($urandom_range(0, 59) == 0) magic_mode = ~magic_mode;
            if ($urandom_range(0, 59) == 0) div_paged = ~div_paged;
            timeout_clr = ($urandom_range(0, 99) == 0);
            r = $urandom_range(0, 39);
            if (r == 0) begin
                bus_if.m1 = 1; bus_if.mreq = 1; bus_if.rd = 1; bus_if.a = 16'h0066;
            end else if (r < 5) begin
                bus_if.a = 16'h0066;
                bus_if.m1 = (r != 1); bus_if.mreq = (r != 2); bus_if.rd = (r != 3 && r != 4);
            end else begin
                bus_if.m1 = 1'($urandom); bus_if.mreq = 1'($urandom); bus_if.rd = 1'($urandom);
                bus_if.a = 16'($urandom);
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
